// File: rtl/serial_mem_responder_pkg.sv
// Shared types and helpers for the bit-serial memory responder:
// FSM states, access-size codes, phase length and byte-lane masks.
package serial_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_READ,
        ST_CAPTURE,
        ST_STREAM,
        ST_ABORT
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int PHASE_LEN = 32;

    // Size code 11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << off;
            SZ_HALF: lane_mask = 4'b0011 << off;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/serial_mem_responder_if.sv
// Serial request/response pins between the core's data serialiser and the responder.
interface serial_mem_responder_if;
    logic       req_valid;
    logic       req_write;
    logic [1:0] req_size;
    logic       req_unsigned;
    logic       ser_in_bit;
    logic       busy;
    logic       rsp_valid;
    logic       rsp_bit;
    logic       done;
    logic       misaligned;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, ser_in_bit,
        input  busy, rsp_valid, rsp_bit, done, misaligned
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, ser_in_bit,
        output busy, rsp_valid, rsp_bit, done, misaligned
    );
endinterface

// File: rtl/serial_mem_responder_lane_align.sv
// Byte-lane alignment: shifts store data up into its lanes with a write mask,
// and shifts load data down then sign/zero-extends it.
module lane_align
    import serial_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_mask,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);
    logic [4:0]  shamt;
    logic [31:0] ld_shift;

    assign shamt    = {off, 3'b000};
    assign st_wdata = st_data << shamt;
    assign st_mask  = lane_mask(size, off);
    assign ld_shift = ld_rdata >> shamt;

    always_comb begin
        ld_data = ld_shift;
        case (size)
            SZ_BYTE: ld_data = {{24{~uns & ld_shift[7]}}, ld_shift[7:0]};
            SZ_HALF: ld_data = {{16{~uns & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end
endmodule

// File: rtl/serial_mem_responder.sv
// Far end of the core's bit-serial load/store link: collects address (and store
// data) LSB first, performs one masked BlockRAM access, streams load data back.
module serial_mem_responder
    import serial_mem_pkg::*;
#(
    parameter int D_WIDTH    = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LANES      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_mem_responder_if.slave bus,
    output logic                  ram_en,
    output logic [LANES-1:0]      ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [D_WIDTH-1:0]    ram_wdata,
    input  logic [D_WIDTH-1:0]    ram_rdata
);
    localparam logic [4:0] LAST_BIT = 5'(PHASE_LEN - 1);

    state_t                state_reg;
    logic [4:0]            cnt_reg;
    logic [31:0]           addr_sr_reg;
    logic [31:0]           data_sr_reg;
    logic [31:0]           out_sr_reg;
    logic                  write_reg;
    logic                  uns_reg;
    logic [1:0]            size_reg;
    logic [1:0]            off_reg;
    logic [ADDR_WIDTH-1:0] waddr_reg;

    // Full word including the bit arriving this cycle.
    logic [31:0] addr_full;
    logic [31:0] data_full;
    logic        misalign;
    logic [31:0] st_wdata;
    logic [3:0]  st_mask;
    logic [31:0] ld_data;

    assign addr_full = {bus.ser_in_bit, addr_sr_reg[31:1]};
    assign data_full = {bus.ser_in_bit, data_sr_reg[31:1]};
    assign misalign  = ((size_reg == SZ_HALF) && addr_full[0]) ||
                       ((size_reg == SZ_WORD) && (addr_full[1:0] != 2'b00));

    lane_align u_lane_align (
        .size     (size_reg),
        .off      (off_reg),
        .uns      (uns_reg),
        .st_data  (data_full),
        .st_wdata (st_wdata),
        .st_mask  (st_mask),
        .ld_rdata (ram_rdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            addr_sr_reg    <= '0;
            data_sr_reg    <= '0;
            out_sr_reg     <= '0;
            write_reg      <= 1'b0;
            uns_reg        <= 1'b0;
            size_reg       <= SZ_BYTE;
            off_reg        <= '0;
            waddr_reg      <= '0;
            bus.busy       <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_bit    <= 1'b0;
            bus.done       <= 1'b0;
            bus.misaligned <= 1'b0;
            ram_en         <= 1'b0;
            ram_we         <= '0;
            ram_addr       <= '0;
            ram_wdata      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        addr_sr_reg <= addr_full;
                        write_reg   <= bus.req_write;
                        size_reg    <= norm_size(bus.req_size);
                        uns_reg     <= bus.req_unsigned;
                        cnt_reg     <= 5'd1;
                        bus.busy    <= 1'b1;
                        state_reg   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    addr_sr_reg <= addr_full;
                    cnt_reg     <= cnt_reg + 5'd1;
                    if (cnt_reg == LAST_BIT) begin
                        off_reg   <= addr_full[1:0];
                        waddr_reg <= addr_full[ADDR_WIDTH+1:2];
                        if (misalign) begin
                            bus.done       <= 1'b1;
                            bus.misaligned <= 1'b1;
                            state_reg      <= ST_ABORT;
                        end else if (write_reg) begin
                            state_reg <= ST_DATA;
                        end else begin
                            ram_en    <= 1'b1;
                            ram_addr  <= addr_full[ADDR_WIDTH+1:2];
                            state_reg <= ST_READ;
                        end
                    end
                end
                ST_DATA: begin
                    data_sr_reg <= data_full;
                    cnt_reg     <= cnt_reg + 5'd1;
                    if (cnt_reg == LAST_BIT) begin
                        ram_en    <= 1'b1;
                        ram_we    <= st_mask;
                        ram_addr  <= waddr_reg;
                        ram_wdata <= st_wdata;
                        bus.done  <= 1'b1;
                        state_reg <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    ram_en    <= 1'b0;
                    ram_we    <= '0;
                    bus.done  <= 1'b0;
                    bus.busy  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                ST_READ: begin
                    ram_en    <= 1'b0;
                    state_reg <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    out_sr_reg    <= ld_data;
                    bus.rsp_bit   <= ld_data[0];
                    bus.rsp_valid <= 1'b1;
                    cnt_reg       <= '0;
                    state_reg     <= ST_STREAM;
                end
                ST_STREAM: begin
                    // rsp_bit already shows bit cnt; stage bit cnt+1 for the next cycle.
                    cnt_reg     <= cnt_reg + 5'd1;
                    out_sr_reg  <= out_sr_reg >> 1;
                    bus.rsp_bit <= out_sr_reg[1];
                    if (cnt_reg == LAST_BIT - 5'd1) begin
                        bus.done <= 1'b1;
                    end
                    if (cnt_reg == LAST_BIT) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_bit   <= 1'b0;
                        bus.done      <= 1'b0;
                        bus.busy      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    bus.done       <= 1'b0;
                    bus.misaligned <= 1'b0;
                    bus.busy       <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_mem_responder.sv
// Randomized scoreboard bench for serial_mem_responder with a byte-level memory model.
module tb_serial_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    serial_mem_responder_if bus ();

    serial_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BlockRAM with byte mask and registered read.
    logic [31:0] ram [1024];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            ram_rdata <= ram[ram_addr];
        end
    end

    // Reference memory contents, updated when a store is issued.
    logic [31:0] ref_mem [1024];

    typedef struct {
        int          kind;   // 0 load, 1 store, 2 aborted
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
        logic [9:0]  waddr;
        logic [31:0] wdata;
        int          start;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compares every DUT-visible event against the head of the queue.
    logic [31:0] mon_bits;
    int          mon_n;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mon_n    = 0;
            mon_bits = '0;
        end else begin
            if (ram_en) begin
                if (exp_q.size() == 0) chk("spurious_ram_en", 1, 0);
                else begin
                    e = exp_q[0];
                    if (e.kind == 2) chk("ram_en_on_abort", 1, 0);
                    else begin
                        chk("ram_en_cycle", cyc - e.start, (e.kind == 1) ? 64 : 32);
                        chk("ram_addr", 32'(ram_addr), 32'(e.waddr));
                        chk("ram_we", 32'(ram_we), (e.kind == 1) ? 32'(e.we) : 0);
                        if (e.kind == 1) chk("ram_wdata", ram_wdata, e.wdata);
                    end
                end
            end else if (ram_we != 4'b0000) begin
                chk("ram_we_without_en", 32'(ram_we), 0);
            end
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 0) chk("spurious_rsp_valid", 1, 0);
                else begin
                    chk("rsp_cycle", cyc - exp_q[0].start, 34 + mon_n);
                    if (mon_n < 32) mon_bits[mon_n] = bus.rsp_bit;
                    mon_n++;
                end
            end
            if (bus.done) begin
                if (exp_q.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc - e.start, (e.kind == 2) ? 32 : (e.kind == 1) ? 64 : 65);
                    chk("misaligned", 32'(bus.misaligned), (e.kind == 2) ? 1 : 0);
                    if (e.kind == 0) begin
                        chk("rsp_count", mon_n, 32);
                        chk("rsp_data", mon_bits, e.data);
                    end
                    $display("[TB] txn kind=%0d addr=%h data=%h we=%b", e.kind, e.addr,
                             (e.kind == 0) ? mon_bits : e.wdata, e.we);
                end
                mon_n    = 0;
                mon_bits = '0;
            end else if (bus.misaligned) begin
                chk("misaligned_without_done", 1, 0);
            end
        end
    end

    task automatic build_exp(input bit wr, input logic [1:0] sz, input bit uns,
                             input logic [31:0] addr, input logic [31:0] data, output exp_t e);
        int off, n;
        logic [31:0] v;
        off     = int'(addr % 4);
        n       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.addr  = addr;
        e.waddr = 10'((addr / 4) % 1024);
        e.we    = '0;
        e.wdata = '0;
        e.data  = '0;
        e.start = 0;
        if (off % n != 0) begin
            e.kind = 2;
        end else if (wr) begin
            e.kind = 1;
            for (int i = 0; i < n; i++) begin
                e.we[off + i] = 1'b1;
                ref_mem[e.waddr][8*(off + i) +: 8] = data[8*i +: 8];
            end
            e.wdata = data << (8 * off);
        end else begin
            e.kind = 0;
            v = ref_mem[e.waddr] >> (8 * off);
            if (n == 1) begin
                v = v & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end else if (n == 2) begin
                v = v & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end
            e.data = v;
        end
    endtask

    task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] data, input bit pulse);
        exp_t e;
        bit   got;
        int   j;
        build_exp(wr, sz, uns, addr, data, e);
        @(posedge clk); #1;
        chk("busy_idle", 32'(bus.busy), 0);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.ser_in_bit   = addr[0];
        e.start          = cyc;
        exp_q.push_back(e);
        for (int i = 1; i < 32; i++) begin
            @(posedge clk); #1;
            bus.req_valid  = pulse && (i == 5);
            bus.ser_in_bit = addr[i];
            if (i == 1) chk("busy_after_accept", 32'(bus.busy), 1);
        end
        got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(posedge clk); #1;
            j = cyc - e.start - 32;
            bus.req_valid  = pulse && (j == 18);
            bus.ser_in_bit = (e.kind == 1 && j >= 0 && j < 32) ? data[j & 31] : 1'b0;
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
        bus.req_valid = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
    endtask

    // Store interrupted by reset in cycle 40: no expectation is queued.
    task automatic store_with_reset(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b1;
        bus.req_size     = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.ser_in_bit   = addr[0];
        for (int i = 1; i < 40; i++) begin
            @(posedge clk); #1;
            bus.req_valid  = 1'b0;
            bus.ser_in_bit = (i < 32) ? addr[i] : data[i - 32];
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        $display("[TB] txn store addr=%h interrupted by reset", addr);
        @(posedge clk); #1;
        rst            = 1'b0;
        bus.ser_in_bit = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.ser_in_bit   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset_rsp_bit", 32'(bus.rsp_bit), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_misaligned", 32'(bus.misaligned), 0);
        chk("reset_ram_en", 32'(ram_en), 0);
        chk("reset_ram_we", 32'(ram_we), 0);
        chk("reset_ram_addr", 32'(ram_addr), 0);
        chk("reset_ram_wdata", ram_wdata, 0);
        rst = 1'b0;

        // Fill words 0..15 through the DUT; word 5 gets the known pattern.
        for (int w = 0; w < 16; w++)
            issue(1'b1, 2'd2, 1'b0, 32'(w * 4), (w == 5) ? 32'h8899_AABB : $urandom, 1'b0);

        issue(1'b0, 2'd2, 1'b0, 32'h14, '0, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h17, '0, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h16, '0, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'h16, '0, 1'b0);
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_1234, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h20, '0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h15, '0, 1'b0);
        issue(1'b1, 2'd1, 1'b0, 32'h23, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 2'd3, 1'b0, 32'h12, '0, 1'b0);
        store_with_reset(32'h30, 32'hCAFE_F00D);
        issue(1'b0, 2'd2, 1'b0, 32'h30, '0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h14, '0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'hFFFF_F014, '0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_mem_responder.md
Name: serial_mem_responder

Overview:
- Memory-side responder for the bit-serial core's load/store path. It is the far end of the serial interface that the core's data serialiser drives.
- It accepts a bit-serial request (byte address, plus store data for writes) one bit per clock, LSB first, and performs a single masked BlockRAM access.
- For loads, it aligns and extends the read word and streams it back serially, LSB first.
- It sits between the core's serial data pins and the BlockRAMwithMask port, replacing direct parallel addressing by the core.

Parameters:
- D_WIDTH, 32, data word width; fixed to 32 for RV32 loads/stores.
- ADDR_WIDTH, 10, BlockRAM word-address width.
- LANES, 4, byte lanes per word (D_WIDTH/8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  start strobe; sampled only in IDLE.
- req_write  in  1  1 = store, 0 = load; sampled with req_valid.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  in  1  zero-extend loads when 1.
- ser_in_bit  in  1  serial address bits, then store-data bits, LSB first.
- busy  out  1  high from the cycle after acceptance until the done cycle, inclusive.
- rsp_valid  out  1  high for exactly 32 cycles while load data streams.
- rsp_bit  out  1  serial load data, LSB first.
- done  out  1  one-cycle pulse at the end of every accepted request.
- misaligned  out  1  one-cycle pulse, coincident with done, on an aborted request.
- ram_en  out  1  BlockRAM enable.
- ram_we  out  LANES  byte write mask.
- ram_addr  out  ADDR_WIDTH  BlockRAM word address.
- ram_wdata  out  D_WIDTH  lane-shifted store data.
- ram_rdata  in  D_WIDTH  BlockRAM read data, valid one cycle after ram_en.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift registers 0.
- Reset mid-operation: return to IDLE immediately. No RAM write may occur, and no done pulse is produced.
- Cycle 0 is the cycle with req_valid=1 in IDLE. Address bit 0 is on ser_in_bit in cycle 0.
- States and timing:
  - IDLE→ADDR: address bits 1..31 arrive in cycles 1..31.
  - ADDR: at the end of cycle 31, compute off=addr[1:0] and word address addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo RAM size.
  - Misalignment check: half with off[0]=1, or word with off≠0, goes to ABORT. ABORT lasts cycle 32: done=1, misaligned=1, ram_en=0, then IDLE. For stores in this case the initiator does not send data.
  - Store: ADDR→DATA. Data bits 0..31 arrive in cycles 32..63.
  - DATA→WRITE, cycle 64: ram_en=1, ram_we=mask, ram_addr=word address, ram_wdata=data<<(8*off), done=1. Then IDLE.
  - Write masks: byte 0001<<off; half 0011<<off; word 1111.
  - Load: ADDR→READ, cycle 32: ram_en=1, ram_we=0.
  - READ→CAPTURE, cycle 33: shift ram_rdata right by 8*off, then sign- or zero-extend from bit 7 (byte) or bit 15 (half). Load into the output shift register.
  - CAPTURE→STREAM, cycles 34..65: rsp_valid=1, rsp_bit=bit k in cycle 34+k. done=1 in cycle 65. Then IDLE.
- busy is low in IDLE only. req_valid while busy is ignored.
- A new request is accepted in the cycle after done.
- ram_we is all-zero in every cycle except WRITE.
- ram_addr and ram_wdata hold their last values when not in use.
- Bit counter is 5 bits and wraps from 31 to 0 at each phase boundary.

Decomposition:
- Package serial_mem_pkg holds:
  - state encoding (IDLE, ADDR, DATA, WRITE, READ, CAPTURE, STREAM, ABORT);
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - a lane-mask function of (size, off);
  - the phase length constant 32.
- One combinational sub-module, lane_align:
  - store direction: data shift and byte mask;
  - load direction: right shift and sign/zero extension.
- The FSM, counter and shift registers live in the top module.

Test Plan:
- Preload RAM word 5 = 0x8899AABB; word load at addr 0x14 → ram_en in cycle 32 with ram_addr=5; rsp_valid for cycles 34..65; streamed value 0x8899AABB; done in cycle 65.
- Signed byte load at addr 0x17 → streamed 0xFFFFFF88. Unsigned byte load at 0x16 → 0x00000099. Unsigned half load at 0x16 → 0x00008899.
- Half store of data 0x00001234 to addr 0x22 → cycle 64 shows ram_addr=8, ram_we=1100, ram_wdata=0x12340000, done=1. A following word load at 0x20 returns the upper half as 0x1234.
- Word load at addr 0x15 → cycle 32 shows done=1 and misaligned=1; ram_en never asserted; busy low in cycle 33.
- Assert rst in cycle 40 of a store → all outputs 0 at once; no ram_we pulse; next request from IDLE completes normally.
- Pulse req_valid during cycles 5 and 50 of a load → ignored; exactly one done pulse; streamed data unchanged.
